// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer: the drain FSM state and one buffered store.
package store_buffer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } drain_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } sb_entry_t;

    // Loads and stores match on the 32-bit word; byte lanes are resolved by the mask.
    function automatic logic word_match(input logic [31:0] a, input logic [31:0] b);
        return a[31:2] == b[31:2];
    endfunction

endpackage

// File: rtl/store_buffer_fifo.sv
// Circular store storage with head/tail pointers, per-entry valid bits and an occupancy count.
module sb_fifo
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  sb_entry_t             push_entry,
    input  logic                  pop,
    output sb_entry_t             head_entry,
    output sb_entry_t [DEPTH-1:0] entries,
    output logic      [DEPTH-1:0] valid,
    output logic      [PTR_W-1:0] head,
    output logic      [CNT_W-1:0] count
);

    logic [PTR_W-1:0] tail;

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + PTR_W'(1);
            end
            if (push) begin
                valid[tail] <= 1'b1;
                tail        <= tail + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Payload needs no reset; nothing reads it unless its valid bit is set.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[tail] <= push_entry;
        end
    end

    assign head_entry = entries[head];

endmodule

// File: rtl/store_buffer.sv
// Store buffer: queues committed stores, drains them in order to data memory, forwards to loads.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_wdata,
    input  logic [3:0]  st_mask,
    input  logic        fence,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_mask,
    input  logic [31:0] ld_addr,
    output logic        ld_hit,
    output logic [31:0] ld_data,
    output logic [3:0]  ld_mask,
    output logic        empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Handshakes: a store transfers on a rising edge with st_valid && st_ready; a write
    // completes on a rising edge with mem_req && mem_ack. Payloads hold until transfer.
    drain_state_e          state, state_next;
    logic                  push, pop;
    sb_entry_t             push_entry, head_entry;
    sb_entry_t [DEPTH-1:0] entries;
    logic      [DEPTH-1:0] valid;
    logic      [PTR_W-1:0] head;
    logic      [CNT_W-1:0] count;
    logic      [PTR_W-1:0] idx;

    assign st_ready   = (count < CNT_W'(DEPTH)) && !fence;
    assign push       = st_valid && st_ready;
    assign pop        = (state == ISSUE) && mem_ack;
    assign push_entry = '{addr: st_addr, wdata: st_wdata, mask: st_mask};
    assign empty      = (count == '0);

    sb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head_entry (head_entry),
        .entries    (entries),
        .valid      (valid),
        .head       (head),
        .count      (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // In ISSUE the buffer is never empty, so only the last entry popping without a refill ends it.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (count != '0) state_next = ISSUE;
            ISSUE:   if (mem_ack && count == CNT_W'(1) && !push) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign mem_req   = (state == ISSUE);
    assign mem_addr  = mem_req ? head_entry.addr  : '0;
    assign mem_wdata = mem_req ? head_entry.wdata : '0;
    assign mem_mask  = mem_req ? head_entry.mask  : '0;

    // Walk oldest to youngest so the last match found is the youngest store.
    always_comb begin
        ld_hit  = 1'b0;
        ld_data = '0;
        ld_mask = '0;
        idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (valid[idx] && word_match(entries[idx].addr, ld_addr)) begin
                ld_hit  = 1'b1;
                ld_data = entries[idx].wdata;
                ld_mask = entries[idx].mask;
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: expected writes queue up at issue, a monitor checks drains.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [31:0] st_addr = '0;
    logic [31:0] st_wdata = '0;
    logic [3:0]  st_mask = '0;
    logic        fence = 1'b0;
    logic        mem_req;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_mask;
    logic [31:0] ld_addr = '0;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic [3:0]  ld_mask;
    logic        empty;

    logic [67:0] exp_q[$];
    logic [67:0] mon_exp;
    int          n_vec = 0;
    int          n_err = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_addr   (st_addr),
        .st_wdata  (st_wdata),
        .st_mask   (st_mask),
        .fence     (fence),
        .mem_req   (mem_req),
        .mem_ack   (mem_ack),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_mask  (mem_mask),
        .ld_addr   (ld_addr),
        .ld_hit    (ld_hit),
        .ld_data   (ld_data),
        .ld_mask   (ld_mask),
        .empty     (empty)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst && mem_req && mem_ack) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got %h/%h/%h expected no write",
                         mem_addr, mem_wdata, mem_mask);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({mem_addr, mem_wdata, mem_mask} !== mon_exp) begin
                    n_err++;
                    $display("FAIL write_order: got %h/%h/%h expected %h/%h/%h",
                             mem_addr, mem_wdata, mem_mask,
                             mon_exp[67:36], mon_exp[35:4], mon_exp[3:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        st_valid = 1'b1;
        st_addr  = a;
        st_wdata = d;
        st_mask  = m;
        exp_q.push_back({a, d, m});
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (st_ready) break;
        end
        if (!st_ready) check("push_accept", 32'(st_ready), 32'd1);
        @(posedge clk);
        #1;
        st_valid = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (empty) break;
        end
        check(name, 32'(empty), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #2 rst = 1'b1;
        @(negedge clk);
        check("rst_mem_req",   32'(mem_req), 32'd0);
        check("rst_mem_addr",  mem_addr,     32'd0);
        check("rst_mem_wdata", mem_wdata,    32'd0);
        check("rst_mem_mask",  32'(mem_mask), 32'd0);
        check("rst_ld_hit",    32'(ld_hit),  32'd0);
        check("rst_ld_data",   ld_data,      32'd0);
        check("rst_ld_mask",   32'(ld_mask), 32'd0);
        check("rst_empty",     32'(empty),   32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_st_ready",  32'(st_ready), 32'd1);

        // single store, ack held high: req one cycle after the push edge
        mem_ack = 1'b1;
        push_store(32'h100, 32'hDEADBEEF, 4'hF);
        check("single_req_push_edge", 32'(mem_req), 32'd0);
        check("single_not_empty",     32'(empty),   32'd0);
        @(posedge clk);
        #1;
        check("single_req_next_edge", 32'(mem_req), 32'd1);
        check("single_mem_addr",      mem_addr,      32'h100);
        @(posedge clk);
        #1;
        check("single_empty_after_ack", 32'(empty),   32'd1);
        check("single_idle_after_ack",  32'(mem_req), 32'd0);

        // fill to DEPTH with no ack, 5th store must be refused
        mem_ack = 1'b0;
        for (int k = 0; k < 4; k++) push_store(32'h10 + 32'(4 * k), 32'hC0DE0000 + 32'(k), 4'hF);
        check("full_st_ready",  32'(st_ready), 32'd0);
        check("full_head_addr", mem_addr,      32'h10);
        st_valid = 1'b1;
        st_addr  = 32'h999;
        st_wdata = 32'h99999999;
        st_mask  = 4'hF;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("full_refuse", 32'(st_ready), 32'd0);
        end
        check("full_head_stable", mem_addr, 32'h10);
        st_valid = 1'b0;
        mem_ack  = 1'b1;
        wait_empty("full_drain_empty");

        // forwarding: youngest of two matches to the same word wins
        mem_ack = 1'b0;
        push_store(32'h200, 32'h11111111, 4'hF);
        push_store(32'h204, 32'h33333333, 4'hF);
        push_store(32'h200, 32'h22222222, 4'h3);
        ld_addr = 32'h202;
        #1;
        check("fwd_hit_youngest",  32'(ld_hit),  32'd1);
        check("fwd_data_youngest", ld_data,      32'h22222222);
        check("fwd_mask_youngest", 32'(ld_mask), 32'h3);
        ld_addr = 32'h207;
        #1;
        check("fwd_hit_single",  32'(ld_hit), 32'd1);
        check("fwd_data_single", ld_data,     32'h33333333);
        ld_addr = 32'h300;
        #1;
        check("fwd_miss_hit",  32'(ld_hit), 32'd0);
        check("fwd_miss_data", ld_data,     32'd0);
        ld_addr = 32'h0;
        mem_ack = 1'b1;
        wait_empty("fwd_drain_empty");

        // full buffer, then streaming stores with continuous ack (pointer wrap)
        mem_ack = 1'b0;
        for (int k = 0; k < 4; k++) push_store(32'h400 + 32'(4 * k), 32'hA0000000 + 32'(k), 4'hF);
        check("wrap_full_ready", 32'(st_ready), 32'd0);
        mem_ack = 1'b1;
        for (int k = 0; k < 10; k++)
            push_store(32'h500 + 32'(4 * k), 32'hB0000000 + 32'(k), 4'(k) | 4'h1);
        wait_empty("wrap_drain_empty");

        // fence blocks new stores but not draining
        mem_ack = 1'b0;
        push_store(32'h600, 32'h66666666, 4'hF);
        push_store(32'h604, 32'h77777777, 4'hC);
        fence = 1'b1;
        #1;
        check("fence_blocks", 32'(st_ready), 32'd0);
        mem_ack = 1'b1;
        wait_empty("fence_drain_empty");
        check("fence_still_blocks", 32'(st_ready), 32'd0);
        fence = 1'b0;
        #1;
        check("fence_release", 32'(st_ready), 32'd1);

        // reset mid-issue discards pending stores
        mem_ack = 1'b0;
        push_store(32'h700, 32'h01010101, 4'hF);
        push_store(32'h704, 32'h02020202, 4'hF);
        push_store(32'h708, 32'h03030303, 4'hF);
        check("pre_rst_req", 32'(mem_req), 32'd1);
        ld_addr = 32'h700;
        #2;
        rst = 1'b1;
        #1;
        check("midrst_mem_req",  32'(mem_req), 32'd0);
        check("midrst_empty",    32'(empty),   32'd1);
        check("midrst_mem_addr", mem_addr,     32'd0);
        check("midrst_ld_hit",   32'(ld_hit),  32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst     = 1'b0;
        mem_ack = 1'b1;
        ld_addr = 32'h0;
        repeat (6) @(posedge clk);
        #1;
        check("postrst_empty",   32'(empty),   32'd1);
        check("postrst_mem_req", 32'(mem_req), 32'd0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
